// File: rtl/data_memory_dbg.sv
// data_memory_dbg: word-organised data RAM shared by the core MEM stage and an
// external debugger.
//   clk_i, rst_i                 clock, async active-high reset
//   mem_rd_i/mem_wr_i/mem_addr_i core request (byte address), write data,
//   mem_wdata_i/mem_be_i         byte enables
//   mem_rdata_o/mem_rvalid_o     registered core read response (1-cycle latency)
//   mem_err_o                    registered misaligned/out-of-range pulse
//   mem_stall_o                  core request not accepted this cycle
//   dm_req_i/dm_we_i/dm_addr_i   debug request (held until grant), full-word
//   dm_wdata_i                   write data
//   dm_gnt_o                     debug request accepted this cycle
//   dm_rvalid_o/dm_rdata_o/      registered debug response, one per grant
//   dm_err_o
module data_memory_dbg #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  mem_rd_i,
   input  logic                  mem_wr_i,
   input  logic [31:0]           mem_addr_i,
   input  logic [DATA_W-1:0]     mem_wdata_i,
   input  logic [DATA_W/8-1:0]   mem_be_i,
   output logic [DATA_W-1:0]     mem_rdata_o,
   output logic                  mem_rvalid_o,
   output logic                  mem_err_o,
   output logic                  mem_stall_o,
   input  logic                  dm_req_i,
   input  logic                  dm_we_i,
   input  logic [31:0]           dm_addr_i,
   input  logic [DATA_W-1:0]     dm_wdata_i,
   output logic                  dm_gnt_o,
   output logic                  dm_rvalid_o,
   output logic [DATA_W-1:0]     dm_rdata_o,
   output logic                  dm_err_o
);

   localparam int unsigned BE_W      = DATA_W / 8;
   localparam int unsigned LSB       = $clog2(BE_W);
   localparam int unsigned IDX_W     = $clog2(DEPTH);
   localparam int unsigned CNT_W     = $clog2(STARVE_MAX + 1);
   localparam logic [32:0] MEM_BYTES = 33'(DEPTH * BE_W);

   // Misaligned or beyond the last byte of the array.
   function automatic logic addr_err(input logic [31:0] a);
      logic misaligned;
      logic out_of_range;
      misaligned   = (a & 32'(BE_W - 1)) != 32'd0;
      out_of_range = {1'b0, a} >= MEM_BYTES;
      return misaligned | out_of_range;
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              mem_rvalid_q, mem_rvalid_d;
   logic              mem_err_q, mem_err_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              dm_rvalid_q, dm_rvalid_d;
   logic              dm_err_q, dm_err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              core_active;
   logic              starve;
   logic              gnt;
   logic              core_acc;
   logic              core_rd_acc;
   logic              core_wr_acc;
   logic              core_err;
   logic              dm_err;
   logic [IDX_W-1:0]  core_idx;
   logic [IDX_W-1:0]  dm_idx;

   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic [BE_W-1:0]   wr_be;

   // Arbitration, address decode and next-state for all response registers.
   always_comb begin
      core_active = mem_rd_i | mem_wr_i;
      starve      = (cnt_q == CNT_W'(STARVE_MAX));
      gnt         = dm_req_i & (~core_active | starve);
      core_acc    = core_active & ~gnt;
      // Simultaneous rd+wr is handled as a write only.
      core_wr_acc = core_acc & mem_wr_i;
      core_rd_acc = core_acc & mem_rd_i & ~mem_wr_i;
      core_err    = addr_err(mem_addr_i);
      dm_err      = addr_err(dm_addr_i);
      core_idx    = mem_addr_i[LSB +: IDX_W];
      dm_idx      = dm_addr_i[LSB +: IDX_W];

      wr_en   = 1'b0;
      wr_idx  = core_idx;
      wr_data = mem_wdata_i;
      wr_be   = mem_be_i;
      if (core_wr_acc && !core_err) begin
         wr_en = 1'b1;
      end else if (gnt && dm_we_i && !dm_err) begin
         wr_en   = 1'b1;
         wr_idx  = dm_idx;
         wr_data = dm_wdata_i;
         wr_be   = {BE_W{1'b1}};
      end

      mem_rvalid_d = core_rd_acc;
      mem_err_d    = core_acc & core_err;
      mem_rdata_d  = mem_rdata_q;
      if (core_rd_acc) begin
         mem_rdata_d = core_err ? '0 : mem_q[core_idx];
      end

      dm_rvalid_d = gnt;
      dm_err_d    = gnt & dm_err;
      dm_rdata_d  = '0;
      if (gnt && !dm_we_i && !dm_err) begin
         dm_rdata_d = mem_q[dm_idx];
      end

      // Counts cycles a pending debug request has been refused.
      cnt_d = cnt_q;
      if (!dm_req_i || gnt) begin
         cnt_d = '0;
      end else if (!starve) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Response and starvation registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_rdata_q  <= '0;
         mem_rvalid_q <= 1'b0;
         mem_err_q    <= 1'b0;
         dm_rdata_q   <= '0;
         dm_rvalid_q  <= 1'b0;
         dm_err_q     <= 1'b0;
         cnt_q        <= '0;
      end else begin
         mem_rdata_q  <= mem_rdata_d;
         mem_rvalid_q <= mem_rvalid_d;
         mem_err_q    <= mem_err_d;
         dm_rdata_q   <= dm_rdata_d;
         dm_rvalid_q  <= dm_rvalid_d;
         dm_err_q     <= dm_err_d;
         cnt_q        <= cnt_d;
      end
   end

   // Storage array: not reset, but writes are suppressed while rst_i is high.
   always_ff @(posedge clk_i) begin
      if (wr_en && !rst_i) begin
         for (int unsigned i = 0; i < BE_W; i++) begin
            if (wr_be[i]) begin
               mem_q[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
         end
      end
   end

   assign mem_rdata_o  = mem_rdata_q;
   assign mem_rvalid_o = mem_rvalid_q;
   assign mem_err_o    = mem_err_q;
   assign mem_stall_o  = core_active & gnt;
   assign dm_gnt_o     = gnt;
   assign dm_rvalid_o  = dm_rvalid_q;
   assign dm_rdata_o   = dm_rdata_q;
   assign dm_err_o     = dm_err_q;

endmodule

// File: tb/tb_data_memory_dbg.sv
// tb_data_memory_dbg: directed vectors for data_memory_dbg with default
// parameters (32-bit words, 32 words, STARVE_MAX=4).
module tb_data_memory_dbg;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        mem_rd_i, mem_wr_i;
   logic [31:0] mem_addr_i, mem_wdata_i;
   logic [3:0]  mem_be_i;
   logic [31:0] mem_rdata_o;
   logic        mem_rvalid_o, mem_err_o, mem_stall_o;
   logic        dm_req_i, dm_we_i;
   logic [31:0] dm_addr_i, dm_wdata_i;
   logic        dm_gnt_o, dm_rvalid_o, dm_err_o;
   logic [31:0] dm_rdata_o;

   int n_checks = 0;
   int n_pass   = 0;

   data_memory_dbg dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i),
      .mem_wdata_i(mem_wdata_i), .mem_be_i(mem_be_i),
      .mem_rdata_o(mem_rdata_o), .mem_rvalid_o(mem_rvalid_o),
      .mem_err_o(mem_err_o), .mem_stall_o(mem_stall_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
      .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
      .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o), .dm_err_o(dm_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic core_acc(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
      mem_rd_i = rd; mem_wr_i = wr; mem_addr_i = addr; mem_wdata_i = wdata; mem_be_i = be;
      tick();
      mem_rd_i = 1'b0; mem_wr_i = 1'b0;
   endtask

   task automatic dm_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wdata;
      #1;
      check("dm_gnt_idle", 32'(dm_gnt_o), 32'd1);
      tick();
      dm_req_i = 1'b0; dm_we_i = 1'b0;
   endtask

   // Core reads every cycle with a debug read held; grant must come in cycle 5.
   task automatic starve_run(input string tag);
      mem_rd_i = 1'b1; mem_addr_i = 32'h0;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h7C;
      for (int c = 1; c <= 5; c++) begin
         #1;
         check($sformatf("%s_gnt_c%0d", tag, c), 32'(dm_gnt_o), (c == 5) ? 32'd1 : 32'd0);
         check($sformatf("%s_stall_c%0d", tag, c), 32'(mem_stall_o), (c == 5) ? 32'd1 : 32'd0);
         tick();
         if (c < 5) check($sformatf("%s_core_rv_c%0d", tag, c), 32'(mem_rvalid_o), 32'd1);
      end
      check({tag, "_dm_rvalid"}, 32'(dm_rvalid_o), 32'd1);
      check({tag, "_dm_rdata"}, dm_rdata_o, 32'h0000_0055);
      check({tag, "_core_rv_stalled"}, 32'(mem_rvalid_o), 32'd0);
      dm_req_i = 1'b0;
      #1;
      check({tag, "_stall_resume"}, 32'(mem_stall_o), 32'd0);
      tick();
      check({tag, "_core_rv_resume"}, 32'(mem_rvalid_o), 32'd1);
      check({tag, "_core_rd_resume"}, mem_rdata_o, 32'h0123_4567);
      mem_rd_i = 1'b0;
      tick();
   endtask

   initial begin
      rst_i = 1'b1;
      mem_rd_i = 1'b0; mem_wr_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; mem_be_i = '0;
      dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
      tick(); tick();
      rst_i = 1'b0;
      check("rst_mem_rdata", mem_rdata_o, 32'h0);
      check("rst_mem_rvalid", 32'(mem_rvalid_o), 32'd0);
      check("rst_mem_err", 32'(mem_err_o), 32'd0);
      check("rst_dm_rvalid", 32'(dm_rvalid_o), 32'd0);
      check("rst_dm_rdata", dm_rdata_o, 32'h0);
      check("rst_dm_err", 32'(dm_err_o), 32'd0);

      // Full-word write then read.
      core_acc(1'b0, 1'b1, 32'h30, 32'hDEAD_BEEF, 4'hF);
      check("wr_err", 32'(mem_err_o), 32'd0);
      check("wr_no_rvalid", 32'(mem_rvalid_o), 32'd0);
      core_acc(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
      check("rd_rvalid", 32'(mem_rvalid_o), 32'd1);
      check("rd_rdata", mem_rdata_o, 32'hDEAD_BEEF);
      check("rd_err", 32'(mem_err_o), 32'd0);
      tick();
      check("idle_rvalid", 32'(mem_rvalid_o), 32'd0);
      check("idle_rdata_hold", mem_rdata_o, 32'hDEAD_BEEF);

      // Byte-enable merge.
      core_acc(1'b0, 1'b1, 32'h30, 32'h1122_3344, 4'b0101);
      core_acc(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
      check("be_merge", mem_rdata_o, 32'hDE22_BE44);

      // Known contents at both ends of the array.
      core_acc(1'b0, 1'b1, 32'h00, 32'h0123_4567, 4'hF);
      core_acc(1'b0, 1'b1, 32'h7C, 32'h89AB_CDEF, 4'hF);

      // Error cases.
      core_acc(1'b1, 1'b0, 32'h32, 32'h0, 4'h0);
      check("mis_rd_err", 32'(mem_err_o), 32'd1);
      check("mis_rd_rdata", mem_rdata_o, 32'h0);
      tick();
      check("err_pulse_clear", 32'(mem_err_o), 32'd0);
      core_acc(1'b0, 1'b1, 32'h80, 32'hFFFF_FFFF, 4'hF);
      check("oor_wr_err", 32'(mem_err_o), 32'd1);
      core_acc(1'b1, 1'b0, 32'h00, 32'h0, 4'h0);
      check("oor_word0", mem_rdata_o, 32'h0123_4567);
      core_acc(1'b1, 1'b0, 32'h7C, 32'h0, 4'h0);
      check("oor_word31", mem_rdata_o, 32'h89AB_CDEF);

      // be=0 is a legal no-op.
      core_acc(1'b0, 1'b1, 32'h30, 32'h0, 4'h0);
      check("be0_err", 32'(mem_err_o), 32'd0);
      core_acc(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
      check("be0_nochange", mem_rdata_o, 32'hDE22_BE44);

      // rd and wr together behave as a write.
      core_acc(1'b1, 1'b1, 32'h7C, 32'h0000_0055, 4'hF);
      check("rdwr_no_rvalid", 32'(mem_rvalid_o), 32'd0);
      core_acc(1'b1, 1'b0, 32'h7C, 32'h0, 4'h0);
      check("rdwr_written", mem_rdata_o, 32'h0000_0055);

      // Debug port while the core is idle.
      dm_acc(1'b0, 32'h30, 32'h0);
      check("dm_rd_rvalid", 32'(dm_rvalid_o), 32'd1);
      check("dm_rd_rdata", dm_rdata_o, 32'hDE22_BE44);
      check("dm_rd_err", 32'(dm_err_o), 32'd0);
      dm_acc(1'b1, 32'h30, 32'hCAFE_F00D);
      check("dm_wr_ack", 32'(dm_rvalid_o), 32'd1);
      check("dm_wr_rdata0", dm_rdata_o, 32'h0);
      dm_acc(1'b0, 32'h30, 32'h0);
      check("dm_rd_back", dm_rdata_o, 32'hCAFE_F00D);
      tick();
      check("dm_rvalid_clear", 32'(dm_rvalid_o), 32'd0);
      dm_acc(1'b0, 32'h31, 32'h0);
      check("dm_mis_err", 32'(dm_err_o), 32'd1);
      check("dm_mis_rdata", dm_rdata_o, 32'h0);
      core_acc(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
      check("core_sees_dm_wr", mem_rdata_o, 32'hCAFE_F00D);

      starve_run("starve");

      // Reset in the cycle after a grant; a core write during reset must not land.
      dm_acc(1'b0, 32'h30, 32'h0);
      check("pre_rst_dm_rvalid", 32'(dm_rvalid_o), 32'd1);
      rst_i = 1'b1;
      mem_wr_i = 1'b1; mem_addr_i = 32'h30; mem_wdata_i = 32'h0; mem_be_i = 4'hF;
      #1;
      check("rst_async_dm_rvalid", 32'(dm_rvalid_o), 32'd0);
      check("rst_async_dm_rdata", dm_rdata_o, 32'h0);
      tick();
      rst_i = 1'b0; mem_wr_i = 1'b0;
      tick();
      check("post_rst_dm_rvalid", 32'(dm_rvalid_o), 32'd0);
      check("post_rst_mem_rvalid", 32'(mem_rvalid_o), 32'd0);
      check("post_rst_mem_rdata", mem_rdata_o, 32'h0);
      core_acc(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
      check("rst_blocks_write", mem_rdata_o, 32'hCAFE_F00D);

      starve_run("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
